// File: rtl/srv_icb_nv1_rr_pkg.sv
// Shared types and helpers for the N:1 round-robin ICB interconnect.
package srv_icb_nv1_rr_pkg;

    localparam int C_W_ADDR_DEF = 32;
    localparam int C_W_DATA_DEF = 32;

    // Default-width command/response records; the top builds width-matched copies from its parameters.
    typedef struct packed {
        logic [C_W_ADDR_DEF-1:0]   addr;
        logic                      read;
        logic [C_W_DATA_DEF-1:0]   wdata;
        logic [C_W_DATA_DEF/8-1:0] wmask;
    } icb_cmd_t;

    typedef struct packed {
        logic [C_W_DATA_DEF-1:0] rdata;
        logic                    err;
    } icb_resp_t;

    function automatic int f_w_id(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/srv_icb_nv1_rr_if.sv
// ICB bundle of N parallel ports (N = 1 for the downstream side).
interface srv_icb_nv1_rr_if #(
    parameter int N      = 1,
    parameter int W_ADDR = 32,
    parameter int W_DATA = 32
);
    logic [N-1:0]                 cmd_valid;
    logic [N-1:0]                 cmd_ready;
    logic [N-1:0][W_ADDR-1:0]     cmd_addr;
    logic [N-1:0]                 cmd_read;
    logic [N-1:0][W_DATA-1:0]     cmd_wdata;
    logic [N-1:0][W_DATA/8-1:0]   cmd_wmask;
    logic [N-1:0]                 resp_valid;
    logic [N-1:0]                 resp_ready;
    logic [N-1:0][W_DATA-1:0]     resp_rdata;
    logic [N-1:0]                 resp_err;

    modport master (
        output cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_wmask, resp_ready,
        input  cmd_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_wmask, resp_ready,
        output cmd_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/srv_icb_nv1_rr_arb.sv
// Round-robin arbiter with a grant lock that holds an offered-but-unaccepted grant.
module srv_icb_nv1_rr_arb
    import srv_icb_nv1_rr_pkg::*;
#(
    parameter int G_N = 2,
    localparam int W_ID = f_w_id(G_N)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [G_N-1:0]  req,
    input  logic            offer_valid,
    input  logic            offer_hs,
    output logic [G_N-1:0]  grant,
    output logic [W_ID-1:0] grant_idx,
    output logic            grant_valid
);
    logic [W_ID-1:0] ptr_q, ptr_d, lock_idx_q, lock_idx_d, pick_idx, cand;
    logic            lock_q, lock_d, pick_found;

    always_comb begin
        pick_idx   = ptr_q;
        pick_found = 1'b0;
        cand       = '0;
        for (int i = 0; i < G_N; i++) begin
            cand = W_ID'((int'(ptr_q) + i) % G_N);
            if (!pick_found && req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end

        grant_idx   = lock_q ? lock_idx_q : pick_idx;
        grant_valid = lock_q ? req[lock_idx_q] : pick_found;
        grant       = grant_valid ? (G_N'(1) << grant_idx) : '0;

        ptr_d      = ptr_q;
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        if (offer_hs) begin
            ptr_d  = (int'(grant_idx) == G_N - 1) ? '0 : grant_idx + 1'b1;
            lock_d = 1'b0;
        end else if (offer_valid) begin
            lock_d     = 1'b1;
            lock_idx_d = grant_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q      <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!reset && lock_q) assert (grant_idx == lock_idx_q);
    end
`endif
endmodule

// File: rtl/srv_sync_fifo.sv
// Small synchronous FIFO; full/empty come from registered occupancy only (no bypass).
module srv_sync_fifo #(
    parameter int DW = 1,
    parameter int DP = 2
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty
);
    localparam int AW = (DP > 1) ? $clog2(DP) : 1;
    localparam int CW = $clog2(DP + 1);

    logic [DW-1:0] mem_q [DP];
    logic [DW-1:0] mem_d [DP];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;

    assign dout  = mem_q[rd_q];
    assign full  = (cnt_q == CW'(DP));
    assign empty = (cnt_q == '0);

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q + CW'(push) - CW'(pop);
        if (push) begin
            mem_d[wr_q] = din;
            wr_d = (int'(wr_q) == DP - 1) ? '0 : wr_q + 1'b1;
        end
        if (pop) begin
            rd_d = (int'(rd_q) == DP - 1) ? '0 : rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            for (int i = 0; i < DP; i++) mem_q[i] <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/srv_icb_nv1_rr.sv
// N:1 ICB interconnect: round-robin command join, in-order ID FIFO for response return.
// SRV_ICB_NV1_CMD_REG_EN adds a 2-entry skid register on the downstream command channel.
module srv_icb_nv1_rr
    import srv_icb_nv1_rr_pkg::*;
#(
    parameter int G_US_NUM = 2,
    parameter int G_W_ADDR = 32,
    parameter int G_W_DATA = 32,
    parameter int G_MPX    = 2
) (
    input  logic             clk,
    input  logic             reset,
    output logic             active,
    srv_icb_nv1_rr_if.slave  us,
    srv_icb_nv1_rr_if.master ds
);
    localparam int W_ID   = f_w_id(G_US_NUM);
    localparam int W_MASK = G_W_DATA / 8;

    typedef struct packed {
        logic [G_W_ADDR-1:0] addr;
        logic                read;
        logic [G_W_DATA-1:0] wdata;
        logic [W_MASK-1:0]   wmask;
    } cmd_t;

    logic [G_US_NUM-1:0] grant;
    logic [W_ID-1:0]     grant_idx, head;
    logic                grant_valid, offer_valid, offer_hs;
    logic                fifo_full, fifo_empty, resp_ready, pop, ds_valid;
    cmd_t                sel_cmd, ds_cmd;

    srv_icb_nv1_rr_arb #(.G_N(G_US_NUM)) u_arb (
        .clk        (clk),
        .reset      (reset),
        .req        (us.cmd_valid),
        .offer_valid(offer_valid),
        .offer_hs   (offer_hs),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .grant_valid(grant_valid)
    );

    always_comb begin
        sel_cmd = '0;
        for (int k = 0; k < G_US_NUM; k++) begin
            if (grant[k]) sel_cmd = {us.cmd_addr[k], us.cmd_read[k], us.cmd_wdata[k], us.cmd_wmask[k]};
        end
    end

`ifdef SRV_ICB_NV1_CMD_REG_EN
    cmd_t       sk0_q, sk0_d, sk1_q, sk1_d;
    logic [1:0] sk_cnt_q, sk_cnt_d;
    logic       sk_out_hs;

    // IDs are pushed on skid entry, so the FIFO count already covers skid contents.
    assign offer_valid = grant_valid & ~fifo_full & (sk_cnt_q != 2'd2) & ~reset;
    assign offer_hs    = offer_valid;
    assign sk_out_hs   = (sk_cnt_q != 2'd0) & ds.cmd_ready[0];

    always_comb begin
        sk0_d    = sk0_q;
        sk1_d    = sk1_q;
        sk_cnt_d = sk_cnt_q + {1'b0, offer_hs} - {1'b0, sk_out_hs};
        if (sk_out_hs) sk0_d = sk1_q;
        if (offer_hs) begin
            if ((sk_cnt_q - {1'b0, sk_out_hs}) == 2'd0) sk0_d = sel_cmd;
            else                                          sk1_d = sel_cmd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sk0_q    <= '0;
            sk1_q    <= '0;
            sk_cnt_q <= '0;
        end else begin
            sk0_q    <= sk0_d;
            sk1_q    <= sk1_d;
            sk_cnt_q <= sk_cnt_d;
        end
    end

    assign ds_valid     = (sk_cnt_q != 2'd0);
    assign ds_cmd       = ds_valid ? sk0_q : '0;
    assign us.cmd_ready = offer_valid ? grant : '0;
`else
    assign offer_valid  = grant_valid & ~fifo_full & ~reset;
    assign offer_hs     = offer_valid & ds.cmd_ready[0];
    assign ds_valid     = offer_valid;
    assign ds_cmd       = offer_valid ? sel_cmd : '0;
    assign us.cmd_ready = (ds.cmd_ready[0] & ~fifo_full & ~reset) ? grant : '0;
`endif

    assign ds.cmd_valid = ds_valid;
    assign ds.cmd_addr  = ds_cmd.addr;
    assign ds.cmd_read  = ds_cmd.read;
    assign ds.cmd_wdata = ds_cmd.wdata;
    assign ds.cmd_wmask = ds_cmd.wmask;

    srv_sync_fifo #(.DW(W_ID), .DP(G_MPX)) u_id_fifo (
        .clk  (clk),
        .rst_b(~reset),
        .push (offer_hs),
        .din  (grant_idx),
        .pop  (pop),
        .dout (head),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    assign resp_ready    = ~fifo_empty & ~reset & us.resp_ready[head];
    assign ds.resp_ready = resp_ready;
    assign pop           = ds.resp_valid[0] & resp_ready;
    assign active        = ~fifo_empty;

    always_comb begin
        us.resp_valid = '0;
        us.resp_rdata = '0;
        us.resp_err   = '0;
        for (int k = 0; k < G_US_NUM; k++) begin
            if (!fifo_empty && !reset && int'(head) == k) begin
                us.resp_valid[k] = ds.resp_valid[0];
                us.resp_rdata[k] = ds.resp_rdata[0];
                us.resp_err[k]   = ds.resp_err[0];
            end
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!reset) assert (!(fifo_empty && ds.resp_valid[0]));
    end
`endif
endmodule
